// File: rtl/pwm_sequencer_if.sv
// Purpose: write-only master bus between pwm_sequencer and its slave.
// Latency: none; the interface only bundles wires.
// Backpressure: the slave stalls by raising master_busy; a write is accepted when master_we=1 and master_busy=0.
// Ports:
//   master_we          request, held high until accepted
//   master_address     write address
//   master_byteSelect  byte lanes, 4'hF during a write
//   master_dataWrite   write data
//   master_busy        slave stall
interface pwm_sequencer_if #(
  parameter int ADDRESS_WIDTH = 24
) ();
  logic                     master_we;
  logic [ADDRESS_WIDTH-1:0] master_address;
  logic [3:0]               master_byteSelect;
  logic [31:0]              master_dataWrite;
  logic                     master_busy;

  modport master (
    output master_we,
    output master_address,
    output master_byteSelect,
    output master_dataWrite,
    input  master_busy
  );

  modport slave (
    input  master_we,
    input  master_address,
    input  master_byteSelect,
    input  master_dataWrite,
    output master_busy
  );
endinterface

// File: rtl/pwm_sequencer.sv
// Purpose: steps through a table of words, writing one to TARGET on the bus per PWM period tick.
// Latency: master_we rises one cycle after the period_tick that starts a step.
// Backpressure: master_busy holds the write (address and data frozen); a tick arriving meanwhile is dropped and flags OVERRUN.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cfg_we/cfg_address/cfg_dataWrite  register write port
//   cfg_dataRead                    combinational register read (unmapped -> 0)
//   period_tick                     one-cycle pulse at each PWM period end
//   bus                             pwm_sequencer_if master modport
//   seq_running                     high whenever the FSM is not IDLE
//   seq_irq                         one-cycle interrupt pulse
// Optional feature: define PWM_SEQUENCER_IRQ_EN to drive seq_irq on DONE/OVERRUN set; otherwise seq_irq is 0.
// Register map: 0 CONTROL {LAST[7:4], LOOP[1], ENABLE[0]}, 1 TARGET,
//   2 STATUS {OVERRUN[10], DONE[9], running[8], index[3:0]}, 16.. TABLE[n].
module pwm_sequencer #(
  parameter int STEPS         = 8,
  parameter int ADDRESS_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_address,
  input  logic [31:0]           cfg_dataWrite,
  output logic [31:0]           cfg_dataRead,
  input  logic                  period_tick,
  pwm_sequencer_if.master       bus,
  output logic                  seq_running,
  output logic                  seq_irq
);

  localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_TICK, WRITE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic                     enable_q;
  logic                     loop_q;
  logic [3:0]               last_q;
  logic [ADDRESS_WIDTH-1:0] target_q;
  logic                     done_q;
  logic                     ovr_q;
  logic [31:0]              data_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [31:0]              table_q [STEPS];

  logic wr_ctrl, wr_tgt, wr_stat, wr_tab, tab_hit;
  logic start, accept;
  logic load, done_set, ovr_set, en_clr;

  assign tab_hit = cfg_address[4] && (32'(cfg_address[3:0]) < 32'(STEPS));
  assign wr_ctrl = cfg_we && (cfg_address == 5'd0);
  assign wr_tgt  = cfg_we && (cfg_address == 5'd1);
  assign wr_stat = cfg_we && (cfg_address == 5'd2);
  assign wr_tab  = cfg_we && tab_hit;

  // Only a 0->1 transition of ENABLE launches a run from IDLE.
  assign start   = wr_ctrl && cfg_dataWrite[0] && !enable_q;
  assign accept  = (state_q == WRITE) && !bus.master_busy;
  // Any tick seen in WRITE (including the acceptance cycle) cannot be served.
  assign ovr_set = period_tick && (state_q == WRITE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    load     = 1'b0;
    done_set = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_TICK;
          idx_d   = 4'd0;
        end
      end
      WAIT_TICK: begin
        if (!enable_q) begin
          state_d = IDLE;
        end else if (period_tick) begin
          state_d = WRITE;
          load    = 1'b1;
        end
      end
      WRITE: begin
        if (accept) begin
          if (!enable_q) begin
            // Disabled while the write was pending: finish it, keep index.
            state_d = IDLE;
          end else if (idx_q < last_q) begin
            idx_d   = 4'(idx_q + 4'd1);
            state_d = WAIT_TICK;
          end else if (loop_q) begin
            idx_d   = 4'd0;
            state_d = WAIT_TICK;
          end else begin
            done_set = 1'b1;
            en_clr   = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      enable_q <= 1'b0;
      loop_q   <= 1'b0;
      last_q   <= 4'd0;
      target_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      data_q   <= 32'd0;
      addr_q   <= '0;
      for (int i = 0; i < STEPS; i++) begin
        table_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;

      if (wr_ctrl) begin
        enable_q <= cfg_dataWrite[0];
        loop_q   <= cfg_dataWrite[1];
        if (32'(cfg_dataWrite[7:4]) >= 32'(STEPS)) begin
          last_q <= 4'(STEPS - 1);
        end else begin
          last_q <= cfg_dataWrite[7:4];
        end
      end
      if (en_clr) begin
        enable_q <= 1'b0;
      end

      if (wr_tgt) begin
        target_q <= cfg_dataWrite[ADDRESS_WIDTH-1:0];
      end
      if (wr_tab) begin
        table_q[cfg_address[IW-1:0]] <= cfg_dataWrite;
      end

      // Snapshot data and address so later cfg writes cannot disturb an in-flight write.
      if (load) begin
        data_q <= table_q[idx_q[IW-1:0]];
        addr_q <= target_q;
      end

      // Sticky status: the clear is applied first so a same-cycle set wins.
      if (wr_stat && cfg_dataWrite[9]) begin
        done_q <= 1'b0;
      end
      if (done_set) begin
        done_q <= 1'b1;
      end
      if (wr_stat && cfg_dataWrite[10]) begin
        ovr_q <= 1'b0;
      end
      if (ovr_set) begin
        ovr_q <= 1'b1;
      end
    end
  end

`ifdef PWM_SEQUENCER_IRQ_EN
  logic irq_q;

  // One pulse per cycle in which either sticky bit is set, even if both are.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_set || ovr_set;
    end
  end

  assign seq_irq = irq_q;
`else
  assign seq_irq = 1'b0;
`endif

  assign seq_running           = (state_q != IDLE);
  assign bus.master_we         = (state_q == WRITE);
  assign bus.master_address    = (state_q == WRITE) ? addr_q : target_q;
  assign bus.master_byteSelect = (state_q == WRITE) ? 4'hF : 4'h0;
  assign bus.master_dataWrite  = (state_q == WRITE) ? data_q : 32'd0;

  always_comb begin
    cfg_dataRead = 32'd0;
    case (cfg_address)
      5'd0:    cfg_dataRead = {24'd0, last_q, 2'b00, loop_q, enable_q};
      5'd1:    cfg_dataRead = 32'(target_q);
      5'd2:    cfg_dataRead = {21'd0, ovr_q, done_q, seq_running, 4'd0, idx_q};
      default: begin
        if (tab_hit) begin
          cfg_dataRead = table_q[cfg_address[IW-1:0]];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Purpose: directed self-checking bench for pwm_sequencer.
// Latency: one vector per clock; inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: master_busy is driven per vector to exercise stalls.
module tb_pwm_sequencer;

`ifdef PWM_SEQUENCER_IRQ_EN
  localparam int IRQ_ON = 1;
`else
  localparam int IRQ_ON = 0;
`endif

  typedef struct {
    int we;
    int a;
    int d;
    int t;
    int b;
    int mwe;
    int mdat;
    int run;
    int irq;
    int rdc;
    int rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [4:0]  cfg_address;
  logic [31:0] cfg_dataWrite;
  logic [31:0] cfg_dataRead;
  logic        period_tick;
  logic        seq_running;
  logic        seq_irq;

  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;
  int   acc0;
  int   tgt_model;
  vec_t vt [28];
  int   lp [5];
  int   rz [4];

  pwm_sequencer_if #(.ADDRESS_WIDTH(24)) bus ();

  pwm_sequencer #(.STEPS(8), .ADDRESS_WIDTH(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we       (cfg_we),
    .cfg_address  (cfg_address),
    .cfg_dataWrite(cfg_dataWrite),
    .cfg_dataRead (cfg_dataRead),
    .period_tick  (period_tick),
    .bus          (bus),
    .seq_running  (seq_running),
    .seq_irq      (seq_irq)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int we, int a, int d, int t, int b,
                              int mwe, int mdat, int run, int irq, int rdc, int rd);
    vec_t v;
    v.we = we; v.a = a; v.d = d; v.t = t; v.b = b;
    v.mwe = mwe; v.mdat = mdat; v.run = run; v.irq = irq; v.rdc = rdc; v.rd = rd;
    return v;
  endfunction

  task automatic cyc(input int r, input int we, input int a, input int d, input int t, input int b);
    @(posedge clk);
    #1;
    rst             = (r != 0);
    cfg_we          = (we != 0);
    cfg_address     = 5'(a);
    cfg_dataWrite   = 32'(d);
    period_tick     = (t != 0);
    bus.master_busy = (b != 0);
    @(negedge clk);
    if (bus.master_we === 1'b1 && bus.master_busy === 1'b0) acc_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_address = 5'd0; cfg_dataWrite = 32'd0;
    period_tick = 1'b0; bus.master_busy = 1'b0;
    tgt_model = 0;

    //           we a   d          t b  mwe mdat  run irq     rdc rd
    vt[0]  = mk(0, 0,  0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[1]  = mk(0, 1,  0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[2]  = mk(0, 2,  0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[3]  = mk(0, 16, 0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[4]  = mk(1, 1,  'h020004,  0,0, 0, 0,    0, 0,      0, 0);
    vt[5]  = mk(1, 16, 'h10,      0,0, 0, 0,    0, 0,      0, 0);
    vt[6]  = mk(1, 17, 'h20,      0,0, 0, 0,    0, 0,      0, 0);
    vt[7]  = mk(1, 18, 'h30,      0,0, 0, 0,    0, 0,      0, 0);
    vt[8]  = mk(0, 1,  0,         0,0, 0, 0,    0, 0,      1, 'h020004);
    vt[9]  = mk(1, 0,  'h21,      0,0, 0, 0,    0, 0,      0, 0);
    vt[10] = mk(0, 0,  0,         0,0, 0, 0,    1, 0,      1, 'h21);
    vt[11] = mk(0, 2,  0,         1,0, 0, 0,    1, 0,      1, 'h100);
    vt[12] = mk(0, 2,  0,         0,0, 1, 'h10, 1, 0,      1, 'h100);
    vt[13] = mk(0, 2,  0,         0,0, 0, 0,    1, 0,      1, 'h101);
    vt[14] = mk(0, 2,  0,         1,0, 0, 0,    1, 0,      1, 'h101);
    vt[15] = mk(0, 2,  0,         0,0, 1, 'h20, 1, 0,      1, 'h101);
    vt[16] = mk(0, 2,  0,         1,0, 0, 0,    1, 0,      1, 'h102);
    vt[17] = mk(0, 2,  0,         0,0, 1, 'h30, 1, 0,      1, 'h102);
    vt[18] = mk(0, 2,  0,         0,0, 0, 0,    0, IRQ_ON, 1, 'h202);
    vt[19] = mk(0, 0,  0,         0,0, 0, 0,    0, 0,      1, 'h20);
    vt[20] = mk(1, 2,  'h200,     0,0, 0, 0,    0, 0,      1, 'h202);
    vt[21] = mk(0, 2,  0,         0,0, 0, 0,    0, 0,      1, 'h002);
    vt[22] = mk(1, 0,  'hF0,      0,0, 0, 0,    0, 0,      0, 0);
    vt[23] = mk(0, 0,  0,         0,0, 0, 0,    0, 0,      1, 'h70);
    vt[24] = mk(1, 0,  0,         0,0, 0, 0,    0, 0,      0, 0);
    vt[25] = mk(0, 3,  0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[26] = mk(0, 24, 0,         0,0, 0, 0,    0, 0,      1, 0);
    vt[27] = mk(0, 18, 0,         0,0, 0, 0,    0, 0,      1, 'h30);

    lp[0] = 'h99; lp[1] = 'h20; lp[2] = 'h99; lp[3] = 'h20; lp[4] = 'h99;
    rz[0] = 1; rz[1] = 2; rz[2] = 16; rz[3] = 17;

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    // Reset state, register access and the basic three-step run.
    for (int i = 0; i < 28; i++) begin
      cyc(0, vt[i].we, vt[i].a, vt[i].d, vt[i].t, vt[i].b);
      chk($sformatf("v%0d_we", i),   32'(bus.master_we),      32'(vt[i].mwe));
      chk($sformatf("v%0d_dat", i),  bus.master_dataWrite,    32'(vt[i].mdat));
      chk($sformatf("v%0d_be", i),   32'(bus.master_byteSelect), (vt[i].mwe != 0) ? 32'hF : 32'h0);
      chk($sformatf("v%0d_addr", i), 32'(bus.master_address), 32'(tgt_model));
      chk($sformatf("v%0d_run", i),  32'(seq_running),        32'(vt[i].run));
      chk($sformatf("v%0d_irq", i),  32'(seq_irq),            32'(vt[i].irq));
      if (vt[i].rdc != 0) chk($sformatf("v%0d_rd", i), cfg_dataRead, 32'(vt[i].rd));
      if (vt[i].we != 0 && vt[i].a == 1) tgt_model = vt[i].d;
    end

    // Stall for 5 cycles; a TABLE[0] rewrite mid-stall must not disturb the frozen word.
    acc0 = acc_cnt;
    cyc(0, 1, 0, 'h01, 0, 0);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, (i == 1) ? 1 : 0, (i == 1) ? 16 : 0, 'h99, 0, (i < 5) ? 1 : 0);
      chk("stall_we",   32'(bus.master_we),      32'h1);
      chk("stall_dat",  bus.master_dataWrite,    32'h10);
      chk("stall_addr", 32'(bus.master_address), 32'h020004);
    end
    cyc(0, 0, 2, 0, 0, 0);
    chk("stall_acc",    32'(acc_cnt - acc0),     32'h1);
    chk("stall_we_off", 32'(bus.master_we),      32'h0);
    chk("stall_status", cfg_dataRead,            32'h200);
    cyc(0, 1, 2, 'h200, 0, 0);

    // Looping over two entries; the new TABLE[0] value is fetched from now on.
    cyc(0, 1, 0, 'h13, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(0, 0, 2, 0, 1, 0);
      cyc(0, 0, 2, 0, 0, 0);
      chk("loop_we",  32'(bus.master_we),   32'h1);
      chk("loop_dat", bus.master_dataWrite, 32'(lp[k]));
    end
    cyc(0, 0, 2, 0, 0, 0);
    chk("loop_status", cfg_dataRead, 32'h101);
    cyc(0, 1, 0, 'h12, 0, 0);
    cyc(0, 0, 2, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0);
    chk("loop_stop_run",    32'(seq_running), 32'h0);
    chk("loop_stop_status", cfg_dataRead,     32'h001);

    // Overrun: tick while stalled, then a clear colliding with another set.
    acc0 = acc_cnt;
    cyc(0, 1, 0, 'h03, 0, 0);
    cyc(0, 0, 2, 0, 1, 0);
    cyc(0, 0, 2, 0, 1, 1);
    chk("ovr_we", 32'(bus.master_we), 32'h1);
    cyc(0, 0, 2, 0, 0, 1);
    chk("ovr_irq",    32'(seq_irq),   32'(IRQ_ON));
    chk("ovr_status", cfg_dataRead,   32'h500);
    cyc(0, 1, 2, 'h400, 1, 1);
    chk("ovr_irq_gap", 32'(seq_irq),  32'h0);
    cyc(0, 0, 2, 0, 0, 0);
    chk("ovr_irq2",       32'(seq_irq),         32'(IRQ_ON));
    chk("ovr_set_wins",   cfg_dataRead,         32'h500);
    chk("ovr_accept_we",  32'(bus.master_we),   32'h1);
    cyc(0, 0, 2, 0, 0, 0);
    chk("ovr_no_extra", 32'(bus.master_we),     32'h0);
    chk("ovr_acc",      32'(acc_cnt - acc0),    32'h1);
    cyc(0, 1, 2, 'h400, 0, 0);
    cyc(0, 0, 2, 0, 0, 0);
    chk("ovr_cleared", cfg_dataRead, 32'h100);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0);
    cyc(0, 0, 2, 0, 0, 0);
    chk("ovr_stop_run", 32'(seq_running), 32'h0);

    // Disable while stalled: the write completes, index stays at 1.
    cyc(0, 1, 0, 'h21, 0, 0);
    cyc(0, 0, 2, 0, 1, 0);
    cyc(0, 0, 2, 0, 0, 0);
    chk("dis_dat0", bus.master_dataWrite, 32'h99);
    cyc(0, 0, 2, 0, 1, 0);
    cyc(0, 1, 0, 'h20, 0, 1);
    chk("dis_we_a", 32'(bus.master_we), 32'h1);
    cyc(0, 0, 2, 0, 0, 1);
    chk("dis_we_b", 32'(bus.master_we),   32'h1);
    chk("dis_dat1", bus.master_dataWrite, 32'h20);
    cyc(0, 0, 2, 0, 0, 0);
    chk("dis_we_acc", 32'(bus.master_we), 32'h1);
    cyc(0, 0, 2, 0, 0, 0);
    chk("dis_we_off", 32'(bus.master_we), 32'h0);
    chk("dis_run",    32'(seq_running),   32'h0);
    chk("dis_status", cfg_dataRead,       32'h001);

    // Reset during a stalled write.
    cyc(0, 1, 0, 'h21, 0, 0);
    cyc(0, 0, 2, 0, 1, 0);
    cyc(1, 0, 2, 0, 0, 1);
    chk("rst_we_before", 32'(bus.master_we), 32'h1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_we",   32'(bus.master_we),         32'h0);
    chk("rst_dat",  bus.master_dataWrite,       32'h0);
    chk("rst_be",   32'(bus.master_byteSelect), 32'h0);
    chk("rst_addr", 32'(bus.master_address),    32'h0);
    chk("rst_run",  32'(seq_running),           32'h0);
    chk("rst_irq",  32'(seq_irq),               32'h0);
    chk("rst_ctrl", cfg_dataRead,               32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, rz[i], 0, 0, 0);
      chk($sformatf("rst_reg%0d", rz[i]), cfg_dataRead, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
